rgen_host_if_axi4lite: RTL
==========================

Name: rgen_host_if_axi4lite

Overview:
AXI4-Lite slave front end for generated register blocks, an alternative to the APB host interface. It converts AXI4-Lite transactions into the internal single-outstanding command/response interface. That interface drives the response mux, the address decoders and the bit-field cells. One transaction is in flight at a time; read and write channels are arbitrated with alternating priority.

Parameters:
DATA_WIDTH, 32, bus and register data width; 32 or 64
HOST_ADDRESS_WIDTH, 16, AXI address width
LOCAL_ADDRESS_WIDTH, 8, byte-address width forwarded to the register block; must be <= HOST_ADDRESS_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_awvalid  in  1  write address valid
o_awready  out  1  write address ready
i_awaddr  in  HOST_ADDRESS_WIDTH  write address
i_awprot  in  3  accepted, ignored
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
i_wdata  in  DATA_WIDTH  write data
i_wstrb  in  DATA_WIDTH/8  byte strobes
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
o_bresp  out  2  write response
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
i_araddr  in  HOST_ADDRESS_WIDTH  read address
i_arprot  in  3  accepted, ignored
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_rdata  out  DATA_WIDTH  read data
o_rresp  out  2  read response
o_command_valid  out  1  command to register block
o_write  out  1  command is write
o_read  out  1  command is read
o_address  out  LOCAL_ADDRESS_WIDTH  local byte address, taken from the low bits of the host address
o_write_data  out  DATA_WIDTH  write data
o_write_mask  out  DATA_WIDTH  bit mask; each wstrb bit is replicated x8
i_response_ready  in  1  one-cycle completion pulse from the response mux
i_read_data  in  DATA_WIDTH  read data, valid while i_response_ready is high
i_status  in  3  completion status; 0 = OKAY, nonzero = error

Behaviour:
- Reset (rst high at a clock edge): state IDLE; all outputs 0; AW/W latched flags cleared; priority favours write. Reset mid-transaction abandons it with no response issued.
- FSM states:
  - IDLE:
    - o_awready = !aw_latched; o_wready = !w_latched; AW and W may arrive in either order or together, and each is latched on its handshake.
    - o_arready = 1 only while neither AW nor W is latched. A partial write blocks reads.
    - Write eligible when AW and W are both latched, or complete this cycle.
    - Read eligible on AR handshake.
    - If a full write and AR are both presented in the same cycle, accept only the one favoured by priority and deassert the other's ready. Priority flips after every issued command.
    - On acceptance, go to COMMAND next cycle.
  - COMMAND:
    - o_command_valid = 1, with o_write or o_read = 1 and address/data/mask held stable.
    - All AXI readies = 0.
    - On i_response_ready: capture read data and status, and drop command_valid in the next cycle.
    - Go to WRITE_RESP or READ_RESP.
  - WRITE_RESP: o_bvalid = 1 until i_bready; o_bresp = 2'b00 if status was 0, else 2'b10 (SLVERR). Clear latched flags; return to IDLE.
  - READ_RESP: o_rvalid = 1 and o_rdata held until i_rready; o_rresp coded as for writes. o_rdata = 0 when not rvalid.
- Latency:
  - Final AW/W or AR handshake at cycle T: command_valid at T+1.
  - i_response_ready at cycle R: bvalid/rvalid at R+1.
  - Ready at R+1: back in IDLE at R+2, new accept possible at R+2.
- i_response_ready outside COMMAND is ignored.
- Address bits above LOCAL_ADDRESS_WIDTH are dropped; unaligned low bits are passed through unchanged.
- wstrb = 0 produces a write command with an all-zero mask.
- All registered outputs are driven from flops; no combinational path from AXI inputs to command outputs.

Decomposition:
- Package rgen_pkg holds:
  - status encoding constants (RGEN_OKAY = 0);
  - AXI response constants (AXI_OKAY = 2'b00, AXI_SLVERR = 2'b10);
  - the FSM state enum.
- The strobe-to-mask expansion is a function in rgen_pkg, shared with the APB interface.
- No sub-module; single flat module.

Test Plan:
- Write: AW and W together (addr 0x0004, data 0xDEADBEEF, strb 4'hF) -> command_valid at T+1, o_address 8'h04, mask 0xFFFFFFFF; status 0 -> bvalid with bresp 00.
- W two cycles before AW (strb 4'b0011) -> wready low after the W handshake, arready low while W is latched; one command issued with mask 0x0000FFFF.
- Read of addr 0x0008: response mux returns 0x12345678 with status 0 -> rvalid with rdata 0x12345678 and rresp 00; rready held low 3 cycles -> rvalid and rdata stable throughout.
- Simultaneous full write and AR after reset -> write issued first, read issued next; repeat -> read first this time.
- i_status = 3'b001 on a read -> rresp 2'b10.
- rst asserted during COMMAND -> all outputs 0 next cycle, no bvalid; a following write completes normally.

Source files
------------

// File: rtl/rgen_pkg.sv
// rgen_pkg: shared status/response encodings, host FSM states and strobe-to-mask expansion
package rgen_pkg;
  localparam logic [2:0] RGEN_OKAY = 3'd0;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMAND,
    ST_WRITE_RESP,
    ST_READ_RESP
  } rgen_state_e;
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction
endpackage

// File: rtl/rgen_host_if_axi4lite.sv
// rgen_host_if_axi4lite: AXI4-Lite slave to single-outstanding register command bridge
module rgen_host_if_axi4lite
  import rgen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int HOST_ADDRESS_WIDTH = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_awvalid,
  output logic                           o_awready,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_awaddr,
  input  logic [2:0]                     i_awprot,
  input  logic                           i_wvalid,
  output logic                           o_wready,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  output logic                           o_bvalid,
  input  logic                           i_bready,
  output logic [1:0]                     o_bresp,
  input  logic                           i_arvalid,
  output logic                           o_arready,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_araddr,
  input  logic [2:0]                     i_arprot,
  output logic                           o_rvalid,
  input  logic                           i_rready,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [1:0]                     o_rresp,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [2:0]                     i_status
);
  rgen_state_e state_q, state_d;
  logic aw_lat_q, aw_lat_d, w_lat_q, w_lat_d, prio_rd_q, prio_rd_d;
  logic cmd_valid_q, cmd_valid_d, write_q, write_d, read_q, read_d, err_q, err_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d, address_q, address_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d, write_mask_q, write_mask_d, rdata_q, rdata_d;
  logic [63:0] mask_full;
  logic idle, wr_cand, rd_cand, wr_block, rd_block, aw_hs, w_hs, wr_go, rd_go, resp;
  logic unused_ok;
  assign unused_ok = ^{i_awprot, i_arprot, i_awaddr, i_araddr};
  always_comb begin
    idle = state_q == ST_IDLE;
    wr_cand = idle && (aw_lat_q || i_awvalid) && (w_lat_q || i_wvalid);
    rd_cand = idle && !aw_lat_q && !w_lat_q && i_arvalid;
    wr_block = wr_cand && rd_cand && prio_rd_q;
    rd_block = wr_cand && rd_cand && !prio_rd_q;
    o_awready = idle && !aw_lat_q && !wr_block;
    o_wready = idle && !w_lat_q && !wr_block;
    o_arready = idle && !aw_lat_q && !w_lat_q && !rd_block;
    aw_hs = i_awvalid && o_awready;
    w_hs = i_wvalid && o_wready;
    wr_go = wr_cand && !wr_block;
    rd_go = i_arvalid && o_arready;
    mask_full = strb_to_mask(8'(i_wstrb));
    awaddr_d = aw_hs ? i_awaddr[LOCAL_ADDRESS_WIDTH-1:0] : awaddr_q;
    wdata_d = w_hs ? i_wdata : wdata_q;
    wmask_d = w_hs ? mask_full[DATA_WIDTH-1:0] : wmask_q;
    aw_lat_d = (aw_lat_q || aw_hs) && !wr_go;
    w_lat_d = (w_lat_q || w_hs) && !wr_go;
    prio_rd_d = prio_rd_q ^ (wr_go || rd_go);
    address_d = wr_go ? awaddr_d : rd_go ? i_araddr[LOCAL_ADDRESS_WIDTH-1:0] : address_q;
    write_data_d = wr_go ? wdata_d : write_data_q;
    write_mask_d = wr_go ? wmask_d : write_mask_q;
    resp = state_q == ST_COMMAND && i_response_ready;
    cmd_valid_d = wr_go || rd_go || (cmd_valid_q && !resp);
    write_d = wr_go || (write_q && !resp);
    read_d = rd_go || (read_q && !resp);
    rdata_d = (resp && read_q) ? i_read_data : rdata_q;
    err_d = resp ? (i_status != RGEN_OKAY) : err_q;
    state_d = (wr_go || rd_go) ? ST_COMMAND
            : resp ? (write_q ? ST_WRITE_RESP : ST_READ_RESP)
            : ((state_q == ST_WRITE_RESP && i_bready) || (state_q == ST_READ_RESP && i_rready)) ? ST_IDLE
            : state_q;
    o_bvalid = state_q == ST_WRITE_RESP;
    o_rvalid = state_q == ST_READ_RESP;
    o_bresp = (o_bvalid && err_q) ? AXI_SLVERR : AXI_OKAY;
    o_rresp = (o_rvalid && err_q) ? AXI_SLVERR : AXI_OKAY;
    o_rdata = o_rvalid ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      aw_lat_q <= 1'b0;
      w_lat_q <= 1'b0;
      prio_rd_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      write_q <= 1'b0;
      read_q <= 1'b0;
      err_q <= 1'b0;
      awaddr_q <= '0;
      address_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      write_data_q <= '0;
      write_mask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      aw_lat_q <= aw_lat_d;
      w_lat_q <= w_lat_d;
      prio_rd_q <= prio_rd_d;
      cmd_valid_q <= cmd_valid_d;
      write_q <= write_d;
      read_q <= read_d;
      err_q <= err_d;
      awaddr_q <= awaddr_d;
      address_q <= address_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      rdata_q <= rdata_d;
    end
  end
  assign o_command_valid = cmd_valid_q;
  assign o_write = write_q;
  assign o_read = read_q;
  assign o_address = address_q;
  assign o_write_data = write_data_q;
  assign o_write_mask = write_mask_q;
endmodule
